// File: rtl/flex_updown_counter_if.sv
// Control/status bundle for flex_updown_counter.
// The master drives the control inputs and observes the counter state;
// the counter itself connects through the slave modport.
interface flex_updown_counter_if #(
   parameter int NUM_CNT_BITS  = 8,
   parameter int WRAP_CNT_BITS = 4
);
   logic                     clear;
   logic                     load;
   logic [NUM_CNT_BITS-1:0]  load_val;
   logic                     count_enable;
   logic                     count_up;
   logic                     saturate;
   logic                     one_shot;
   logic [NUM_CNT_BITS-1:0]  rollover_val;
   logic [NUM_CNT_BITS-1:0]  count_out;
   logic                     rollover_flag;
   logic                     wrap_pulse;
   logic [WRAP_CNT_BITS-1:0] wrap_count;
   logic                     halted;

   modport master (
      output clear, load, load_val, count_enable, count_up, saturate, one_shot, rollover_val,
      input  count_out, rollover_flag, wrap_pulse, wrap_count, halted
   );

   modport slave (
      input  clear, load, load_val, count_enable, count_up, saturate, one_shot, rollover_val,
      output count_out, rollover_flag, wrap_pulse, wrap_count, halted
   );
endinterface

// File: rtl/flex_updown_counter.sv
// Up/down counter over 1..rollover_val with wrap or saturate at the terminal
// value, parallel load, one-shot halt, wrap pulse and a saturating wrap tally.
// All outputs come straight from registers.
module flex_updown_counter #(
   parameter int NUM_CNT_BITS  = 8,
   parameter int WRAP_CNT_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   flex_updown_counter_if.slave bus
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE = NUM_CNT_BITS'(1);
   localparam logic [WRAP_CNT_BITS-1:0] WC_ONE  = WRAP_CNT_BITS'(1);
   localparam logic [WRAP_CNT_BITS-1:0] WC_MAX  = '1;

   state_t                   state_q, state_d;
   logic [NUM_CNT_BITS-1:0]  count_q, count_d;
   logic                     flag_q, flag_d;
   logic                     pulse_q, pulse_d;
   logic [WRAP_CNT_BITS-1:0] wc_q, wc_d;

   logic [NUM_CNT_BITS-1:0]  step_cnt;
   logic                     step_wrap;
   logic                     step_hit;
   logic                     step_ok;

   // A zero range makes every step a no-op: no movement, no wrap, no flag.
   assign step_ok = bus.count_enable && (bus.rollover_val != '0);

   // Candidate count for one step. Comparing with >= / <= (rather than ==)
   // also catches out-of-range values left behind by a load, so count+1 can
   // never overflow the register.
   always_comb begin
      step_cnt  = count_q;
      step_wrap = 1'b0;
      if (bus.count_up) begin
         if (count_q < bus.rollover_val) begin
            step_cnt = count_q + CNT_ONE;
         end else if (bus.saturate) begin
            step_cnt = bus.rollover_val;
         end else begin
            step_cnt  = CNT_ONE;
            step_wrap = 1'b1;
         end
      end else begin
         if (count_q > CNT_ONE) begin
            step_cnt = count_q - CNT_ONE;
         end else if (bus.saturate) begin
            step_cnt = CNT_ONE;
         end else begin
            step_cnt  = bus.rollover_val;
            step_wrap = 1'b1;
         end
      end
      step_hit = (step_cnt == (bus.count_up ? bus.rollover_val : CNT_ONE));
   end

   // Next state: clear > load > enabled step > hold; HALT ignores enable.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      flag_d  = flag_q;
      pulse_d = 1'b0;
      wc_d    = wc_q;
      if (bus.clear) begin
         state_d = RUN;
         count_d = '0;
         flag_d  = 1'b0;
         wc_d    = '0;
      end else if (bus.load) begin
         state_d = RUN;
         count_d = bus.load_val;
         flag_d  = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (step_ok) begin
                  count_d = step_cnt;
                  flag_d  = step_hit;
                  pulse_d = step_wrap;
                  if (step_wrap && (wc_q != WC_MAX)) wc_d = wc_q + WC_ONE;
                  if (bus.one_shot && step_hit) state_d = HALT;
               end else begin
                  flag_d = 1'b0;
               end
            end
            HALT: begin
               // Everything holds (flag stays at the 1 it was set to on entry).
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         count_q <= '0;
         flag_q  <= 1'b0;
         pulse_q <= 1'b0;
         wc_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         flag_q  <= flag_d;
         pulse_q <= pulse_d;
         wc_q    <= wc_d;
      end
   end

   assign bus.count_out     = count_q;
   assign bus.rollover_flag = flag_q;
   assign bus.wrap_pulse    = pulse_q;
   assign bus.wrap_count    = wc_q;
   assign bus.halted        = (state_q == HALT);

endmodule

// File: tb/tb_flex_updown_counter.sv
// Bench for flex_updown_counter: directed scenarios followed by random
// traffic. The driver applies inputs at the falling edge and queues the
// reference model's prediction for the following rising edge; a separate
// monitor pops and compares after each rising edge.
module tb_flex_updown_counter;

   localparam int NB   = 8;
   localparam int WB   = 4;
   localparam int WMAX = (1 << WB) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   flex_updown_counter_if #(.NUM_CNT_BITS(NB), .WRAP_CNT_BITS(WB)) ifc ();

   flex_updown_counter #(.NUM_CNT_BITS(NB), .WRAP_CNT_BITS(WB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   typedef struct {
      int cnt;
      int flag;
      int pulse;
      int wc;
      int halt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state, plain integers.
   int m_cnt, m_flag, m_pulse, m_wc, m_halt;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_flag = 0; m_pulse = 0; m_wc = 0; m_halt = 0;
   endtask

   // One clock edge of the counter, written straight from the behavioural rules.
   task automatic model_edge(input int clr, input int ld, input int lv, input int en,
                             input int up, input int sat, input int os, input int r);
      int nxt, term, wrapped;
      if (clr != 0) begin
         model_reset();
      end else if (ld != 0) begin
         m_cnt = lv; m_flag = 0; m_pulse = 0; m_halt = 0;
      end else if (m_halt != 0) begin
         m_pulse = 0;
      end else if (en != 0 && r != 0) begin
         wrapped = 0;
         if (up != 0) begin
            term = r;
            if (m_cnt < r)        nxt = m_cnt + 1;
            else if (sat != 0)    nxt = r;
            else begin nxt = 1; wrapped = 1; end
         end else begin
            term = 1;
            if (m_cnt > 1)        nxt = m_cnt - 1;
            else if (sat != 0)    nxt = 1;
            else begin nxt = r; wrapped = 1; end
         end
         m_cnt   = nxt;
         m_flag  = (nxt == term) ? 1 : 0;
         m_pulse = wrapped;
         if (wrapped != 0 && m_wc < WMAX) m_wc = m_wc + 1;
         if (os != 0 && nxt == term) m_halt = 1;
      end else begin
         m_flag = 0; m_pulse = 0;
      end
   endtask

   task automatic drive(input int clr, input int ld, input int lv, input int en,
                        input int up, input int sat, input int os, input int r);
      exp_t e;
      @(negedge clk);
      ifc.clear        = 1'(clr);
      ifc.load         = 1'(ld);
      ifc.load_val     = NB'(lv);
      ifc.count_enable = 1'(en);
      ifc.count_up     = 1'(up);
      ifc.saturate     = 1'(sat);
      ifc.one_shot     = 1'(os);
      ifc.rollover_val = NB'(r);
      model_edge(clr, ld, lv, en, up, sat, os, r);
      e = '{m_cnt, m_flag, m_pulse, m_wc, m_halt};
      sb.push_back(e);
   endtask

   task automatic idle_inputs();
      ifc.clear = 1'b0; ifc.load = 1'b0; ifc.load_val = '0; ifc.count_enable = 1'b0;
      ifc.count_up = 1'b1; ifc.saturate = 1'b0; ifc.one_shot = 1'b0; ifc.rollover_val = '0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".count_out"},     int'(ifc.count_out), 0);
      chk({tag, ".rollover_flag"}, int'(ifc.rollover_flag), 0);
      chk({tag, ".wrap_pulse"},    int'(ifc.wrap_pulse), 0);
      chk({tag, ".wrap_count"},    int'(ifc.wrap_count), 0);
      chk({tag, ".halted"},        int'(ifc.halted), 0);
   endtask

   // Monitor: compares every cycle for which a prediction is queued.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("count_out",     int'(ifc.count_out),     e.cnt);
            chk("rollover_flag", int'(ifc.rollover_flag), e.flag);
            chk("wrap_pulse",    int'(ifc.wrap_pulse),    e.pulse);
            chk("wrap_count",    int'(ifc.wrap_count),    e.wc);
            chk("halted",        int'(ifc.halted),        e.halt);
         end
      end
   end

   initial begin
      int r_cur, clr, ld, lv, en, up, sat, os;
      rst = 1'b1;
      idle_inputs();
      model_reset();
      #12;
      chk_reset_vals("reset");
      @(negedge clk);
      rst = 1'b0;

      // Up wrap, R=4: 1,2,3,4,1,2
      repeat (6) drive(0, 0, 0, 1, 1, 0, 0, 4);

      // Down from 3, R=5, wrap then saturate
      drive(1, 0, 0, 0, 1, 0, 0, 5);
      drive(0, 1, 3, 0, 0, 0, 0, 5);
      repeat (4) drive(0, 0, 0, 1, 0, 0, 0, 5);
      drive(0, 1, 3, 0, 0, 1, 0, 5);
      repeat (4) drive(0, 0, 0, 1, 0, 1, 0, 5);

      // One-shot at R=3, held in HALT, then reload 0 and resume
      drive(1, 0, 0, 0, 1, 0, 1, 3);
      repeat (8) drive(0, 0, 0, 1, 1, 0, 1, 3);
      drive(0, 1, 0, 1, 1, 0, 1, 3);
      repeat (2) drive(0, 0, 0, 1, 1, 0, 1, 3);

      // Priority: clear over load over step
      drive(0, 1, 7, 0, 1, 0, 0, 10);
      drive(1, 1, 9, 1, 1, 0, 0, 10);
      drive(0, 1, 9, 1, 1, 0, 0, 10);

      // R=0 holds in both directions
      drive(0, 1, 2, 0, 1, 0, 0, 0);
      repeat (4) drive(0, 0, 0, 1, 1, 0, 0, 0);
      repeat (2) drive(0, 0, 0, 1, 0, 0, 0, 0);

      // R=1 wraps every cycle; tally saturates
      drive(1, 0, 0, 0, 1, 0, 0, 1);
      repeat (20) drive(0, 0, 0, 1, 1, 0, 0, 1);

      // Halt at 6, then async reset mid-cycle
      drive(1, 0, 0, 0, 1, 0, 0, 6);
      drive(0, 1, 5, 0, 1, 0, 1, 6);
      repeat (4) drive(0, 0, 0, 1, 1, 0, 1, 6);
      @(posedge clk);
      #4;
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 1, 1, 0, 0, 6);

      // Random traffic
      r_cur = 5;
      repeat (400) begin
         if ($urandom_range(0, 7) == 0)
            r_cur = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 9));
         clr = ($urandom_range(0, 31) == 0) ? 1 : 0;
         ld  = ($urandom_range(0, 15) == 0) ? 1 : 0;
         lv  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 12));
         en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
         up  = int'($urandom_range(0, 1));
         sat = ($urandom_range(0, 3) == 0) ? 1 : 0;
         os  = ($urandom_range(0, 7) == 0) ? 1 : 0;
         drive(clr, ld, lv, en, up, sat, os, r_cur);
      end

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
